// File: rtl/ide_taskfile_port.sv
// ide_taskfile_port
//   Device-side ATA responder for one IDE channel. Holds the task file and a
//   one-sector (256 x 16) buffer shared between the CPU register window and
//   the HPS strobe interface.
//
// Ports
//   clk_sys, reset_n        system clock, asynchronous active-low reset
//   hps_addr[4:0]           [4] channel select, [3:0] register
//                           (0-7 task file, 8 control, F data port)
//   hps_rd, hps_wr          one-cycle HPS read-advance / write strobes
//   hps_din, hps_dout       HPS write data / registered HPS read data
//   hps_req[1:0]            [0] command pending, [1] CPU-written sector ready
//   cpu_sel, cpu_addr[2:0]  CPU register window select and ATA register index
//   cpu_rd, cpu_wr          one-cycle CPU read / write strobes
//   cpu_din, cpu_dout       CPU write data / registered CPU read data
//   irq                     ATA interrupt to Gayle
//
// Strobe protocol: every rd/wr strobe is a single-cycle pulse and is acted on
// at the clock edge where it is high; there is no back-pressure. hps_dout is
// registered and reflects hps_addr/hps_ptr one clock after either changes, so
// the HPS end samples hps_dout first and then pulses hps_rd to advance.
// cpu_dout carries the read result in the cycle after cpu_rd.
module ide_taskfile_port #(
  parameter int CHANNEL = 0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [4:0]  hps_addr,
  input  logic        hps_rd,
  input  logic        hps_wr,
  input  logic [15:0] hps_din,
  output logic [15:0] hps_dout,
  output logic [1:0]  hps_req,
  input  logic        cpu_sel,
  input  logic [2:0]  cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        irq
);

  localparam logic CH_BIT = CHANNEL[0];

  localparam int ST_BSY = 7;
  localparam int ST_DRQ = 3;

  logic [7:0]  tf [0:7];      // entries 1..6 used: features/error .. drive/head
  logic [7:0]  command;
  logic [7:0]  status;
  logic        dev_nien;      // device-control nIEN, loaded via HPS addr 8
  logic [7:0]  hps_ptr;
  logic [7:0]  cpu_ptr;
  logic [15:0] mem [0:255];

  // HPS side decode
  logic       hps_hit;
  logic [3:0] hps_reg;
  logic       hps_we, hps_re;
  logic       hps_stat_wr, hps_cmd_rd, hps_buf_wr, hps_buf_adv;
  logic       hps_tf_wr, hps_ctl_wr;

  assign hps_hit     = (hps_addr[4] == CH_BIT);
  assign hps_reg     = hps_addr[3:0];
  assign hps_we      = hps_wr & hps_hit;
  assign hps_re      = hps_rd & hps_hit;
  assign hps_stat_wr = hps_we && (hps_reg == 4'h7);
  assign hps_cmd_rd  = hps_re && (hps_reg == 4'h7);
  assign hps_buf_wr  = hps_we && (hps_reg == 4'hF);
  assign hps_buf_adv = hps_buf_wr || (hps_re && (hps_reg == 4'hF));
  assign hps_tf_wr   = hps_we && (hps_reg >= 4'h1) && (hps_reg <= 4'h6);
  assign hps_ctl_wr  = hps_we && (hps_reg == 4'h8);

  // CPU side decode. A status write from the HPS in the same cycle takes the
  // pointer and DRQ, so any CPU data access in that cycle is dropped.
  logic cpu_we, cpu_re, drq;
  logic cpu_data_wr, cpu_data_rd, cpu_data_acc, cpu_wrap;
  logic cpu_cmd_wr, cpu_tf_wr, cpu_stat_rd;

  assign cpu_we       = cpu_sel & cpu_wr;
  assign cpu_re       = cpu_sel & cpu_rd;
  assign drq          = status[ST_DRQ];
  assign cpu_data_wr  = cpu_we && (cpu_addr == 3'd0) && drq && !hps_stat_wr;
  assign cpu_data_rd  = cpu_re && (cpu_addr == 3'd0) && drq && !hps_stat_wr;
  assign cpu_data_acc = cpu_data_wr | cpu_data_rd;
  assign cpu_wrap     = cpu_data_acc && (cpu_ptr == 8'hFF);
  assign cpu_cmd_wr   = cpu_we && (cpu_addr == 3'd7);
  assign cpu_tf_wr    = cpu_we && (cpu_addr != 3'd0) && (cpu_addr != 3'd7);
  assign cpu_stat_rd  = cpu_re && (cpu_addr == 3'd7);

  // Sector buffer: HPS port and CPU port. The DRQ protocol keeps the two
  // ports off the same word, so no collision handling is needed.
  always_ff @(posedge clk_sys) begin
    if (hps_buf_wr)  mem[hps_ptr] <= hps_din;
    if (cpu_data_wr) mem[cpu_ptr] <= cpu_din;
  end

  // Task file, command, status, pointers, request flags, interrupt
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) tf[i] <= 8'h00;
      command  <= 8'h00;
      status   <= 8'h50;
      dev_nien <= 1'b0;
      hps_ptr  <= 8'h00;
      cpu_ptr  <= 8'h00;
      hps_req  <= 2'b00;
      irq      <= 1'b0;
    end else begin
      // HPS write after CPU write so an HPS readback load overrides
      if (cpu_tf_wr) tf[cpu_addr] <= cpu_din[7:0];
      if (hps_tf_wr) tf[hps_reg[2:0]] <= hps_din[7:0];

      if (cpu_cmd_wr) command <= cpu_din[7:0];
      if (hps_ctl_wr) dev_nien <= hps_din[1];

      if (hps_stat_wr) begin
        status <= hps_din[7:0];
      end else if (cpu_cmd_wr || cpu_wrap) begin
        status[ST_BSY] <= 1'b1;
        status[ST_DRQ] <= 1'b0;
      end

      if (hps_stat_wr)       cpu_ptr <= 8'h00;
      else if (cpu_data_acc) cpu_ptr <= cpu_ptr + 8'd1;

      if (hps_stat_wr || hps_cmd_rd) hps_ptr <= 8'h00;
      else if (hps_buf_adv)          hps_ptr <= hps_ptr + 8'd1;

      // a new command beats a simultaneous HPS fetch of the previous one
      if (cpu_cmd_wr)      hps_req[0] <= 1'b1;
      else if (hps_cmd_rd) hps_req[0] <= 1'b0;

      if (hps_stat_wr)                  hps_req[1] <= 1'b0;
      else if (cpu_wrap && cpu_data_wr) hps_req[1] <= 1'b1;

      if (hps_stat_wr && !hps_din[ST_BSY] && !dev_nien) irq <= 1'b1;
      else if (cpu_cmd_wr || cpu_stat_rd)               irq <= 1'b0;
    end
  end

  // Registered HPS read mux
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hps_dout <= 16'h0000;
    end else if (!hps_hit) begin
      hps_dout <= 16'h0000;
    end else begin
      case (hps_reg)
        4'h1, 4'h2, 4'h3,
        4'h4, 4'h5, 4'h6: hps_dout <= {8'h00, tf[hps_reg[2:0]]};
        4'h7:             hps_dout <= {8'h00, command};
        4'h8:             hps_dout <= {14'd0, hps_req};
        4'hF:             hps_dout <= mem[hps_ptr];
        default:          hps_dout <= 16'h0000;
      endcase
    end
  end

  // Registered CPU read data
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_dout <= 16'h0000;
    end else if (cpu_re) begin
      case (cpu_addr)
        3'd0:    cpu_dout <= cpu_data_rd ? mem[cpu_ptr] : 16'hFFFF;
        3'd7:    cpu_dout <= {8'h00, status};
        default: cpu_dout <= {8'h00, tf[cpu_addr]};
      endcase
    end
  end

endmodule

// File: tb/tb_ide_taskfile_port.sv
module tb_ide_taskfile_port;

  logic        clk_sys;
  logic        reset_n;
  logic [4:0]  hps_addr;
  logic        hps_rd;
  logic        hps_wr;
  logic [15:0] hps_din;
  logic [15:0] hps_dout;
  logic [1:0]  hps_req;
  logic        cpu_sel;
  logic [2:0]  cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  ide_taskfile_port #(.CHANNEL(0)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .hps_addr (hps_addr),
    .hps_rd   (hps_rd),
    .hps_wr   (hps_wr),
    .hps_din  (hps_din),
    .hps_dout (hps_dout),
    .hps_req  (hps_req),
    .cpu_sel  (cpu_sel),
    .cpu_addr (cpu_addr),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .irq      (irq)
  );

  // clock / reset
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic hps_write(input logic [4:0] a, input logic [15:0] d);
    hps_addr = a; hps_din = d; hps_wr = 1'b1;
    tick();
    hps_wr = 1'b0;
    tick();
  endtask

  task automatic hps_peek(input logic [4:0] a, output logic [15:0] d);
    hps_addr = a;
    tick(); tick();
    d = hps_dout;
  endtask

  task automatic hps_read(input logic [4:0] a, output logic [15:0] d);
    hps_peek(a, d);
    hps_rd = 1'b1;
    tick();
    hps_rd = 1'b0;
    tick();
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    cpu_sel = 1'b1; cpu_addr = a; cpu_din = d; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0; cpu_sel = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    cpu_sel = 1'b1; cpu_addr = a; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0; cpu_sel = 1'b0;
    d = cpu_dout;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] d;
    reset_n = 1'b0;
    hps_addr = 5'h00; hps_rd = 1'b0; hps_wr = 1'b0; hps_din = 16'h0000;
    cpu_sel = 1'b0; cpu_addr = 3'd0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_din = 16'h0000;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    checks++; if (hps_req !== 2'b00) begin errors++; $display("FAIL reset_req got %b exp 00", hps_req); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if (hps_dout !== 16'h0000) begin errors++; $display("FAIL reset_hps_dout got %h exp 0000", hps_dout); end
    checks++; if (cpu_dout !== 16'h0000) begin errors++; $display("FAIL reset_cpu_dout got %h exp 0000", cpu_dout); end
    cpu_read(3'd7, d);
    checks++; if (d !== 16'h0050) begin errors++; $display("FAIL reset_status got %h exp 0050", d); end
  endtask

  task automatic test_command();
    logic [15:0] d;
    cpu_write(3'd3, 16'h0012);
    cpu_write(3'd7, 16'h0020);
    tick();
    checks++; if (hps_req !== 2'b01) begin errors++; $display("FAIL cmd_req got %b exp 01", hps_req); end
    hps_peek(5'h03, d);
    checks++; if (d !== 16'h0012) begin errors++; $display("FAIL cmd_lba0 got %h exp 0012", d); end
    hps_peek(5'h08, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL cmd_ctrl got %h exp 0001", d); end
    cpu_read(3'd7, d);
    checks++; if (d !== 16'h00D0) begin errors++; $display("FAIL cmd_status got %h exp 00D0", d); end
    hps_read(5'h07, d);
    checks++; if (d !== 16'h0020) begin errors++; $display("FAIL cmd_read got %h exp 0020", d); end
    checks++; if (hps_req !== 2'b00) begin errors++; $display("FAIL cmd_req_clr got %b exp 00", hps_req); end
  endtask

  task automatic test_pio_read();
    logic [15:0] d;
    for (int i = 0; i < 256; i++) hps_write(5'h0F, 16'(i));
    hps_write(5'h07, 16'h0058);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pior_irq got %b exp 1", irq); end
    cpu_read(3'd7, d);
    checks++; if (d !== 16'h0058) begin errors++; $display("FAIL pior_status got %h exp 0058", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pior_irq_clr got %b exp 0", irq); end
    for (int i = 0; i < 256; i++) begin
      cpu_read(3'd0, d);
      checks++;
      if (d !== 16'(i)) begin errors++; $display("FAIL pior_word[%0d] got %h exp %h", i, d, 16'(i)); end
    end
    cpu_read(3'd7, d);
    checks++; if (d !== 16'h00D0) begin errors++; $display("FAIL pior_end_status got %h exp 00D0", d); end
    checks++; if (hps_req !== 2'b00) begin errors++; $display("FAIL pior_req got %b exp 00", hps_req); end
  endtask

  task automatic test_drq_off();
    logic [15:0] d;
    cpu_read(3'd0, d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL drq0_read got %h exp FFFF", d); end
    cpu_read(3'd7, d);
    checks++; if (d !== 16'h00D0) begin errors++; $display("FAIL drq0_status got %h exp 00D0", d); end
    cpu_write(3'd0, 16'hBEEF);
    hps_peek(5'h0F, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL drq0_write_ignored got %h exp 0000", d); end
  endtask

  task automatic test_hps_taskfile();
    logic [15:0] d;
    hps_write(5'h01, 16'h0004);
    cpu_read(3'd1, d);
    checks++; if (d !== 16'h0004) begin errors++; $display("FAIL hps_tf_error got %h exp 0004", d); end
    hps_peek(5'h01, d);
    checks++; if (d !== 16'h0004) begin errors++; $display("FAIL hps_tf_readback got %h exp 0004", d); end
  endtask

  task automatic test_pio_write();
    logic [15:0] d;
    hps_write(5'h07, 16'h0058);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL piow_irq got %b exp 1", irq); end
    cpu_read(3'd7, d);
    checks++; if (d !== 16'h0058) begin errors++; $display("FAIL piow_status got %h exp 0058", d); end
    for (int i = 0; i < 255; i++) cpu_write(3'd0, 16'hA500 + 16'(i));
    checks++; if (hps_req !== 2'b00) begin errors++; $display("FAIL piow_req_early got %b exp 00", hps_req); end
    cpu_write(3'd0, 16'hA5FF);
    checks++; if (hps_req !== 2'b10) begin errors++; $display("FAIL piow_req got %b exp 10", hps_req); end
    cpu_read(3'd7, d);
    checks++; if (d !== 16'h00D0) begin errors++; $display("FAIL piow_end_status got %h exp 00D0", d); end
    hps_read(5'h07, d);
    checks++; if (d !== 16'h0020) begin errors++; $display("FAIL piow_cmd got %h exp 0020", d); end
    for (int i = 0; i < 256; i++) begin
      hps_read(5'h0F, d);
      checks++;
      if (d !== 16'hA500 + 16'(i)) begin errors++; $display("FAIL piow_word[%0d] got %h exp %h", i, d, 16'hA500 + 16'(i)); end
    end
    hps_write(5'h07, 16'h0050);
    checks++; if (hps_req !== 2'b00) begin errors++; $display("FAIL piow_req_clr got %b exp 00", hps_req); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL piow_done_irq got %b exp 1", irq); end
    cpu_read(3'd7, d);
    checks++; if (d !== 16'h0050) begin errors++; $display("FAIL piow_done_status got %h exp 0050", d); end
  endtask

  task automatic test_other_channel();
    logic [15:0] d;
    hps_write(5'h17, 16'h0000);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL chan_irq got %b exp 0", irq); end
    hps_write(5'h13, 16'h0077);
    cpu_read(3'd3, d);
    checks++; if (d !== 16'h0012) begin errors++; $display("FAIL chan_tf got %h exp 0012", d); end
    hps_peek(5'h13, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL chan_dout got %h exp 0000", d); end
    hps_write(5'h1F, 16'h1234);
    hps_read(5'h1F, d);
    hps_peek(5'h0F, d);
    checks++; if (d !== 16'hA500) begin errors++; $display("FAIL chan_buf got %h exp A500", d); end
    cpu_read(3'd7, d);
    checks++; if (d !== 16'h0050) begin errors++; $display("FAIL chan_status got %h exp 0050", d); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] d;
    // command write against HPS fetch of addr 7
    hps_addr = 5'h07; hps_rd = 1'b1;
    cpu_sel = 1'b1; cpu_addr = 3'd7; cpu_din = 16'h0030; cpu_wr = 1'b1;
    tick();
    hps_rd = 1'b0; cpu_wr = 1'b0; cpu_sel = 1'b0;
    tick();
    checks++; if (hps_req !== 2'b01) begin errors++; $display("FAIL sim_cmd_req got %b exp 01", hps_req); end
    hps_peek(5'h07, d);
    checks++; if (d !== 16'h0030) begin errors++; $display("FAIL sim_cmd got %h exp 0030", d); end
    // HPS status write against a CPU data read
    hps_write(5'h07, 16'h0058);
    cpu_read(3'd0, d);
    checks++; if (d !== 16'hA500) begin errors++; $display("FAIL sim_first_word got %h exp A500", d); end
    hps_addr = 5'h07; hps_din = 16'h0058; hps_wr = 1'b1;
    cpu_sel = 1'b1; cpu_addr = 3'd0; cpu_rd = 1'b1;
    tick();
    hps_wr = 1'b0; cpu_rd = 1'b0; cpu_sel = 1'b0;
    tick();
    cpu_read(3'd0, d);
    checks++; if (d !== 16'hA500) begin errors++; $display("FAIL sim_ptr_reset got %h exp A500", d); end
  endtask

  task automatic test_nien();
    logic [15:0] d;
    cpu_read(3'd7, d);
    checks++; if (d !== 16'h0058) begin errors++; $display("FAIL nien_status got %h exp 0058", d); end
    hps_write(5'h08, 16'h0002);
    hps_write(5'h07, 16'h0050);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL nien_masked got %b exp 0", irq); end
    hps_write(5'h08, 16'h0000);
    hps_write(5'h07, 16'h0050);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL nien_unmasked got %b exp 1", irq); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] d;
    hps_write(5'h07, 16'h0058);
    for (int i = 0; i < 100; i++) cpu_write(3'd0, 16'h3C00 + 16'(i));
    cpu_read(3'd3, d);
    checks++; if (hps_req !== 2'b01) begin errors++; $display("FAIL mid_req_before got %b exp 01", hps_req); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (hps_req !== 2'b00) begin errors++; $display("FAIL mid_req got %b exp 00", hps_req); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got %b exp 0", irq); end
    checks++; if (cpu_dout !== 16'h0000) begin errors++; $display("FAIL mid_cpu_dout got %h exp 0000", cpu_dout); end
    tick();
    reset_n = 1'b1;
    tick();
    cpu_read(3'd7, d);
    checks++; if (d !== 16'h0050) begin errors++; $display("FAIL mid_status got %h exp 0050", d); end
    cpu_read(3'd3, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mid_tf got %h exp 0000", d); end
    hps_peek(5'h0F, d);
    checks++; if (d !== 16'h3C00) begin errors++; $display("FAIL mid_hps_ptr got %h exp 3C00", d); end
    cpu_read(3'd0, d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL mid_drq got %h exp FFFF", d); end
  endtask

  initial begin
    test_reset();
    test_command();
    test_pio_read();
    test_drq_off();
    test_hps_taskfile();
    test_pio_write();
    test_other_channel();
    test_simultaneous();
    test_nien();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ide_taskfile_port.md
Name: ide_taskfile_port

Overview:
- Device-side responder for the HPS IDE access path; one instance per IDE channel.
- Holds the ATA task file (8 registers) and a one-sector (256 x 16) data buffer shared between the Amiga CPU (Gayle side) and the HPS strobe interface.
- The HPS end reads commands and sector data, writes sector data and status, and polls request flags.
- The CPU sees a standard ATA register window with DRQ/BSY handshaking and an interrupt.

Parameters:
- CHANNEL, 0, value of hps_addr[4] this instance answers to.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- hps_addr  in  5  [4] channel select, [3:0] register (0-7 task file, 8 control, F data port)
- hps_rd  in  1  one-cycle read-advance strobe (data already sampled from hps_dout)
- hps_wr  in  1  one-cycle write strobe
- hps_din  in  16  HPS write data
- hps_dout  out  16  HPS read data for current hps_addr/pointer
- hps_req  out  2  [0] command pending, [1] CPU-written sector ready
- cpu_sel  in  1  register window selected
- cpu_addr  in  3  ATA register index
- cpu_rd  in  1  one-cycle CPU read strobe
- cpu_wr  in  1  one-cycle CPU write strobe
- cpu_din  in  16  CPU write data
- cpu_dout  out  16  CPU read data, registered
- irq  out  1  ATA interrupt to Gayle

Behaviour:
- Reset (async, reset_n=0):
  - all task-file registers 0, status=8'h50 (DRDY|DSC)
  - both pointers 0; hps_req=0, irq=0, hps_dout=0, cpu_dout=0
  - buffer contents undefined
- HPS accesses with hps_addr[4]!=CHANNEL are ignored; hps_dout is driven 0 for them.
- hps_dout selection:
  - registered; valid 1 clk after any change of hps_addr or hps_ptr
  - the HPS end spaces strobes by >=2 clk
  - addr 0-6: task-file values as written by the CPU
  - addr 7: {8'h00, command}
  - addr 8: {14'd0, hps_req}
  - addr F: buf[hps_ptr]
- HPS read of addr 7:
  - on hps_rd: clear hps_req[0], set hps_ptr=0
- HPS write addr 1-6:
  - loads the CPU-visible readback value: error, seccount, lba0, lba1, lba2, drive/head
  - CPU-written values are overwritten
- HPS write addr 7: status <= hps_din[7:0]; in the same cycle:
  - hps_ptr=0, cpu_ptr=0, hps_req[1]=0
  - if new BSY=0 and device control nIEN=0: irq=1
- HPS write addr F:
  - buf[hps_ptr] <= hps_din, hps_ptr++ (8-bit, wraps 255->0)
  - hps_rd at addr F: hps_ptr++
- CPU writes:
  - reg 1-6: store features/seccount/lba/drive
  - reg 7 (command): command <= din[7:0]; status BSY=1, DRQ=0; hps_req[0]=1; irq=0
  - reg 0 with DRQ=1: buf[cpu_ptr] <= cpu_din, cpu_ptr++
  - on wrap 255->0: DRQ=0, BSY=1, hps_req[1]=1
  - reg 0 with DRQ=0: ignored
- CPU reads:
  - cpu_dout valid the cycle after cpu_rd
  - reg 7 read returns status and clears irq
  - reg 0 with DRQ=1: returns buf[cpu_ptr], cpu_ptr++; on wrap: DRQ=0, BSY=1
  - reg 0 with DRQ=0: returns 16'hFFFF, pointer unchanged
- Command write while BSY=1:
  - accepted; the command is overwritten and hps_req[0] stays 1 (latest command wins)
- Simultaneous events:
  - HPS status write and CPU data access in the same cycle: the HPS write wins (pointer reset, DRQ from hps_din); the CPU access is dropped
  - CPU command write and HPS addr-7 read in the same cycle: hps_req[0] ends at 1
- Buffer is true dual-port; simultaneous same-address access is not protected (excluded by the DRQ protocol).

Test Plan:
- Reset values: deassert reset_n -> CPU reg7 read = 16'h0050, hps_req=0, irq=0.
- Command pending flag:
  - stimulus: CPU writes lba0=8'h12, then cmd=8'h20
  - response: hps_req=2'b01; HPS addr 3 reads 16'h0012; HPS addr 7 read returns 16'h0020 and clears hps_req[0]
- PIO read sector:
  - stimulus: HPS writes 256 words 16'h0000..16'h00FF to F, then status 8'h58
  - response: irq=1; CPU status read = 8'h58 and irq=0; 256 CPU reg0 reads return 0..255 in order; then status BSY=1, DRQ=0
- PIO write sector:
  - stimulus: HPS status 8'h58, then CPU writes 256 words 16'hA500+i
  - response: hps_req[1]=1 after the 256th write; HPS addr-7 read resets hps_ptr; 256 F reads with hps_rd return 16'hA500..16'hA5FF
- Boundaries:
  - CPU reg0 read with DRQ=0 returns 16'hFFFF, pointer unchanged
  - access with hps_addr[4]=~CHANNEL leaves all state unchanged, hps_dout=0
- Mid-transfer reset:
  - stimulus: assert reset_n low after 100 CPU data words
  - response: pointers 0, status 8'h50, hps_req=0 immediately (async)
